stream_release_tap: RTL
=======================

Name: stream_release_tap

Overview:
- Sits at the exit of a semaphore-guarded pipeline (e.g. rasterizer → fragment pipeline → framebuffer writer).
- Accepts the pipeline's AXI-Stream output and buffers it in a small FIFO before forwarding it downstream.
- Generates the per-element release pulse that the entry-side semaphore uses to decrement its in-flight count.
- Also reports completed packets (tlast) and a drained/idle status.

Parameters:
- FIFO_DEPTH, 4, number of buffered elements; power of two, ≥ 2.
- STREAM_WIDTH, 32, tdata width.
- KEEP_WIDTH, 1, tkeep width.
- PKT_CNT_WIDTH, 16, width of the completed-packet counter.

Ports:
- aclk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- s_axis_tvalid  in  1  pipeline output valid.
- s_axis_tready  out  1  FIFO can accept.
- s_axis_tlast  in  1  end of packet.
- s_axis_tdata  in  STREAM_WIDTH  payload.
- s_axis_tkeep  in  KEEP_WIDTH  byte enables.
- m_axis_tvalid  out  1  downstream valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  forwarded tlast.
- m_axis_tdata  out  STREAM_WIDTH  forwarded payload.
- m_axis_tkeep  out  KEEP_WIDTH  forwarded tkeep.
- sigRelease  out  1  one-cycle pulse per element accepted downstream.
- pktDone  out  1  one-cycle pulse when an element with tlast is accepted downstream.
- pktCount  out  PKT_CNT_WIDTH  running count of completed packets.
- pktCountClear  in  1  synchronous clear of pktCount.
- idle  out  1  FIFO empty and no release pending.

Behaviour:
- Reset (async assert, sync deassert):
  - FIFO empty; read/write pointers 0; occupancy 0.
  - m_axis_tvalid=0, sigRelease=0, pktDone=0, pktCount=0.
  - s_axis_tready=1 after deassert; idle=1.
  - m_axis_tdata/tkeep/tlast=0.
- Storage: circular buffer of FIFO_DEPTH entries {tlast, tkeep, tdata}.
  - Pointers are log2(FIFO_DEPTH)+1 bits.
  - Full when the MSBs differ and the LSBs are equal; empty when the pointers are equal.
  - Wrap-around is natural binary rollover.
- Write: on s_axis_tvalid && s_axis_tready. s_axis_tready = !full and is combinational from registered state only.
- Read: registered output stage.
  - m_axis_tvalid is registered.
  - Data is held stable while tvalid && !tready.
  - The output register refills from the FIFO in the same cycle as a downstream handshake.
  - Throughput is 1 element/cycle.
  - Latency input→output: 1 cycle when the FIFO is empty (write cycle N, m_axis_tvalid at N+1).
- Occupancy: counts FIFO entries plus the output register, so total capacity is FIFO_DEPTH+1.
  - Simultaneous read and write leaves occupancy unchanged.
  - When completely full with tready=1 on the output, s_axis_tready stays 0 that cycle. No same-cycle pass-through (no combinational ready path).
- sigRelease:
  - Registered; asserted for exactly one cycle in cycle N+1 for each downstream handshake (m_axis_tvalid && m_axis_tready) in cycle N.
  - Consecutive handshakes produce sigRelease held high on consecutive cycles, one count per cycle. No coalescing and no loss.
- pktDone: registered; same timing as sigRelease, qualified by m_axis_tlast.
- pktCount:
  - Increments together with pktDone; saturates at all-ones (no wrap).
  - pktCountClear has priority over increment; clear and increment in the same cycle give 0.
- idle: registered; 1 when occupancy==0 and no sigRelease is pending for the next cycle.
- Reset mid-operation: buffered elements are discarded. No sigRelease is issued for them; the entry-side semaphore is reset in the same domain.
- Back-to-back tlast elements each produce their own pktDone pulse.

Test Plan:
- Single element (tdata=0xA5A5A5A5, tlast=1), m_axis_tready=1 → m_axis_tvalid at cycle+1 with the same data; sigRelease and pktDone high at cycle+2 for exactly 1 cycle; pktCount=1; idle returns 1.
- Stream of 16 elements at full rate, tready=1 throughout → output data in order; sigRelease high for 16 consecutive cycles; s_axis_tready never drops.
- m_axis_tready=0, push elements → exactly FIFO_DEPTH+1=5 accepted, s_axis_tready=0 thereafter, m_axis_tdata stable on the first element; release tready → all 5 drain in order, 5 sigRelease pulses total.
- Simultaneous push and pop while at occupancy 3 → occupancy stays 3 and s_axis_tready stays 1 across 10 cycles; pointer wrap verified past index FIFO_DEPTH-1.
- pktCount: with PKT_CNT_WIDTH=4, send 17 tlast elements → pktCount saturates at 15; assert pktCountClear in the same cycle as a pktDone increment → pktCount=0.
- Assert reset asynchronously mid-burst with 3 elements buffered → outputs go to reset values without a clock edge; no sigRelease afterwards; idle=1 after deassert.

Source files
------------

// File: rtl/stream_release_tap.sv
// Output buffer at the exit of a semaphore-guarded pipeline: FIFO plus registered
// output stage, per-element release pulse, packet-done pulse/counter and idle status.
module stream_release_tap #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned STREAM_WIDTH  = 32,
    parameter int unsigned KEEP_WIDTH    = 1,
    parameter int unsigned PKT_CNT_WIDTH = 16
) (
    input  logic                     aclk,
    input  logic                     reset,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic [STREAM_WIDTH-1:0]  s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [STREAM_WIDTH-1:0]  m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic                     sigRelease,
    output logic                     pktDone,
    output logic [PKT_CNT_WIDTH-1:0] pktCount,
    input  logic                     pktCountClear,
    output logic                     idle
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    typedef logic [AW:0] ptr_t;

    logic [STREAM_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [KEEP_WIDTH-1:0]   mem_keep [FIFO_DEPTH];
    logic                    mem_last [FIFO_DEPTH];

    ptr_t          wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, fifo_cnt_nxt;
    logic [AW-1:0] wr_idx, rd_idx;
    logic          full, empty, wr_hs, m_hs, out_load, bypass, fifo_wr, fifo_rd;
    logic          tvalid_nxt, idle_nxt;

    assign wr_idx        = wr_ptr[AW-1:0];
    assign rd_idx        = rd_ptr[AW-1:0];
    assign empty         = (wr_ptr == rd_ptr);
    assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign s_axis_tready = !full;
    assign wr_hs         = s_axis_tvalid && !full;
    assign m_hs          = m_axis_tvalid && m_axis_tready;
    assign out_load      = !m_axis_tvalid || m_axis_tready;
    // An empty FIFO lets a new element go straight into the output register,
    // giving single-cycle latency without a combinational ready path.
    assign bypass        = out_load && empty;
    assign fifo_wr       = wr_hs && !bypass;
    assign fifo_rd       = out_load && !empty;

    always_comb begin
        wr_ptr_nxt   = wr_ptr + ptr_t'(fifo_wr);
        rd_ptr_nxt   = rd_ptr + ptr_t'(fifo_rd);
        fifo_cnt_nxt = wr_ptr_nxt - rd_ptr_nxt;
        tvalid_nxt   = out_load ? (fifo_rd || wr_hs) : 1'b1;
        idle_nxt     = (fifo_cnt_nxt == '0) && !tvalid_nxt && !m_hs;
    end

    always_ff @(posedge aclk) begin
        if (fifo_wr) begin
            mem_data[wr_idx] <= s_axis_tdata;
            mem_keep[wr_idx] <= s_axis_tkeep;
            mem_last[wr_idx] <= s_axis_tlast;
        end
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            sigRelease    <= 1'b0;
            pktDone       <= 1'b0;
            pktCount      <= '0;
            idle          <= 1'b1;
        end else begin
            wr_ptr        <= wr_ptr_nxt;
            rd_ptr        <= rd_ptr_nxt;
            m_axis_tvalid <= tvalid_nxt;
            if (fifo_rd) begin
                m_axis_tdata <= mem_data[rd_idx];
                m_axis_tkeep <= mem_keep[rd_idx];
                m_axis_tlast <= mem_last[rd_idx];
            end else if (bypass && wr_hs) begin
                m_axis_tdata <= s_axis_tdata;
                m_axis_tkeep <= s_axis_tkeep;
                m_axis_tlast <= s_axis_tlast;
            end
            sigRelease <= m_hs;
            pktDone    <= m_hs && m_axis_tlast;
            if (pktCountClear)
                pktCount <= '0;
            else if (m_hs && m_axis_tlast && (pktCount != '1))
                pktCount <= pktCount + 1'b1;
            idle <= idle_nxt;
        end
    end
endmodule
